// File: rtl/dice_game_ctrl_if.sv
// Bus between the dice game controller and its surroundings.
// Carries the roll/new-game controls and live dice values into the
// controller, and the latched dice, score and game status back out.
//   master : the side that drives roll/new_game/dice (counter block, bench)
//   slave  : the controller itself
interface dice_game_ctrl_if #(
   parameter int DICE_W     = 3,
   parameter int ROLL_CNT_W = 8
);
   logic                  roll;
   logic                  new_game;
   logic [DICE_W-1:0]     dice1_in;
   logic [DICE_W-1:0]     dice2_in;
   logic [DICE_W-1:0]     dice1_val;
   logic [DICE_W-1:0]     dice2_val;
   logic [3:0]            sum;
   logic [3:0]            point;
   logic                  point_valid;
   logic                  win;
   logic                  lose;
   logic                  busy;
   logic [ROLL_CNT_W-1:0] roll_count;

   modport master (
      output roll, new_game, dice1_in, dice2_in,
      input  dice1_val, dice2_val, sum, point, point_valid,
             win, lose, busy, roll_count
   );

   modport slave (
      input  roll, new_game, dice1_in, dice2_in,
      output dice1_val, dice2_val, sum, point, point_valid,
             win, lose, busy, roll_count
   );
endinterface

// File: rtl/dice_game_ctrl.sv
// Craps sequencing controller.
// Turns a rising edge of the roll button into one sample of both free-running
// dice counters, scores the roll (come-out / point phase) and keeps the game
// status for the display/LED logic.
// Ports:
//   clk  : system clock, single domain
//   rst  : synchronous active-high reset
//   bus  : dice_game_ctrl_if.slave
//          in : roll (debounced level), new_game (1-cycle pulse),
//               dice1_in/dice2_in (live dice, valid range 1..6)
//          out: dice1_val/dice2_val/sum (last scored roll), point/point_valid,
//               win/lose (held until cleared), busy, roll_count (saturating)
module dice_game_ctrl #(
   parameter int DICE_W     = 3,
   parameter int ROLL_CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   dice_game_ctrl_if.slave     bus
);

   typedef enum logic [2:0] {
      ST_COME_OUT,
      ST_POINT,
      ST_SAMPLE,
      ST_EVAL,
      ST_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  ret_point_q, ret_point_d;
   logic                  roll_prev_q, roll_prev_d;
   logic [DICE_W-1:0]     dice1_q, dice1_d;
   logic [DICE_W-1:0]     dice2_q, dice2_d;
   logic [3:0]            sum_q, sum_d;
   logic [3:0]            point_q, point_d;
   logic                  point_valid_q, point_valid_d;
   logic                  win_q, win_d;
   logic                  lose_q, lose_d;
   logic [ROLL_CNT_W-1:0] roll_count_q, roll_count_d;

   logic roll_edge;
   logic dice_ok;
   logic clear_game;
   logic is_natural;
   logic is_craps;
   logic is_seven;
   logic hit_point;

   // Decoded conditions shared by the next-state and datapath logic.
   // A counter value of 0 or 7 means the dice block is mid-wrap; such a
   // sample is not a real roll and is retried on the next cycle.
   assign roll_edge  = bus.roll & ~roll_prev_q;
   assign dice_ok    = (bus.dice1_in >= DICE_W'(1)) && (bus.dice1_in <= DICE_W'(6)) &&
                       (bus.dice2_in >= DICE_W'(1)) && (bus.dice2_in <= DICE_W'(6));
   assign clear_game = bus.new_game | ((state_q == ST_DONE) & roll_edge);
   assign is_natural = (sum_q == 4'd7) || (sum_q == 4'd11);
   assign is_craps   = (sum_q == 4'd2) || (sum_q == 4'd3) || (sum_q == 4'd12);
   assign is_seven   = (sum_q == 4'd7);
   assign hit_point  = (sum_q == point_q);

   // State register plus all datapath flops. Reset wins over everything, so a
   // roll caught mid-SAMPLE/EVAL leaves nothing behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_COME_OUT;
         ret_point_q   <= 1'b0;
         roll_prev_q   <= 1'b0;
         dice1_q       <= '0;
         dice2_q       <= '0;
         sum_q         <= '0;
         point_q       <= '0;
         point_valid_q <= 1'b0;
         win_q         <= 1'b0;
         lose_q        <= 1'b0;
         roll_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         ret_point_q   <= ret_point_d;
         roll_prev_q   <= roll_prev_d;
         dice1_q       <= dice1_d;
         dice2_q       <= dice2_d;
         sum_q         <= sum_d;
         point_q       <= point_d;
         point_valid_q <= point_valid_d;
         win_q         <= win_d;
         lose_q        <= lose_d;
         roll_count_q  <= roll_count_d;
      end
   end

   // Next-state logic. new_game overrides any state, which also drops a
   // roll edge arriving in the same cycle. Roll edges seen in SAMPLE/EVAL
   // are simply not looked at, so they are never queued.
   always_comb begin
      state_d = state_q;
      if (bus.new_game) begin
         state_d = ST_COME_OUT;
      end else begin
         case (state_q)
            ST_COME_OUT, ST_POINT: begin
               if (roll_edge) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
               if (dice_ok) state_d = ST_EVAL;
            end
            ST_EVAL: begin
               if (ret_point_q) begin
                  state_d = (hit_point || is_seven) ? ST_DONE : ST_POINT;
               end else begin
                  state_d = (is_natural || is_craps) ? ST_DONE : ST_POINT;
               end
            end
            ST_DONE: begin
               if (roll_edge) state_d = ST_COME_OUT;
            end
            default: state_d = ST_COME_OUT;
         endcase
      end
   end

   // Datapath/output logic. Clearing a game leaves the last dice and sum on
   // display; only the scoring status and roll count are wiped.
   always_comb begin
      ret_point_d   = ret_point_q;
      roll_prev_d   = bus.roll;
      dice1_d       = dice1_q;
      dice2_d       = dice2_q;
      sum_d         = sum_q;
      point_d       = point_q;
      point_valid_d = point_valid_q;
      win_d         = win_q;
      lose_d        = lose_q;
      roll_count_d  = roll_count_q;

      if (clear_game) begin
         point_d       = '0;
         point_valid_d = 1'b0;
         win_d         = 1'b0;
         lose_d        = 1'b0;
         roll_count_d  = '0;
      end else begin
         case (state_q)
            ST_COME_OUT, ST_POINT: begin
               if (roll_edge) ret_point_d = (state_q == ST_POINT);
            end
            ST_SAMPLE: begin
               if (dice_ok) begin
                  dice1_d = bus.dice1_in;
                  dice2_d = bus.dice2_in;
                  sum_d   = 4'(bus.dice1_in) + 4'(bus.dice2_in);
                  if (roll_count_q != {ROLL_CNT_W{1'b1}}) begin
                     roll_count_d = roll_count_q + ROLL_CNT_W'(1);
                  end
               end
            end
            ST_EVAL: begin
               if (ret_point_q) begin
                  if (hit_point)     win_d  = 1'b1;
                  else if (is_seven) lose_d = 1'b1;
               end else begin
                  if (is_natural)    win_d  = 1'b1;
                  else if (is_craps) lose_d = 1'b1;
                  else begin
                     point_d       = sum_q;
                     point_valid_d = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.dice1_val   = dice1_q;
   assign bus.dice2_val   = dice2_q;
   assign bus.sum         = sum_q;
   assign bus.point       = point_q;
   assign bus.point_valid = point_valid_q;
   assign bus.win         = win_q;
   assign bus.lose        = lose_q;
   assign bus.busy        = (state_q == ST_SAMPLE) || (state_q == ST_EVAL);
   assign bus.roll_count  = roll_count_q;

endmodule
